// File: rtl/OoO_pkg.sv
// Shared core types: AXI read/write channel structs and the simple memory request/response port.
package OoO_pkg;

   typedef struct packed {
      logic        awvalid;
      logic [31:0] awaddr;
      logic        wvalid;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        bready;
   } axi_w_m2s_t;

   typedef struct packed {
      logic awready;
      logic wready;
      logic bvalid;
   } axi_w_s2m_t;

   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic        rlast;
   } axi_r_s2m_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } mem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } mem_rsp_t;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/mem_axi_master.sv
// Single-outstanding AXI initiator: turns one load/store request into AXI read or write traffic
// and returns one response; a watchdog forces an error response when the responder hangs.
module mem_axi_master
   import OoO_pkg::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output axi_w_m2s_t  m_w_m2s,
   input  axi_w_s2m_t  m_w_s2m,
   output axi_r_m2s_t  m_r_m2s,
   input  axi_r_s2m_t  m_r_s2m
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4,
      RESP    = 3'd5
   } state_e;

   localparam int unsigned    WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

   state_e          state_q, state_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   mem_rsp_t        rsp_q, rsp_d;
   logic            awvalid_q, awvalid_d;
   logic            wvalid_q, wvalid_d;
   logic            arvalid_q, arvalid_d;
   logic            bready_q, bready_d;
   logic            rready_q, rready_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [WD_W-1:0] wd_q, wd_d;

   mem_req_t req_in;
   logic     aw_hs, w_hs, ar_hs, r_beat, b_beat, wd_fire, abort;

   function automatic logic in_wait(input state_e s);
      return (s == RD_ADDR) || (s == RD_DATA) || (s == WR_REQ) || (s == WR_RESP);
   endfunction

   assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

   assign aw_hs   = awvalid_q && m_w_s2m.awready;
   assign w_hs    = wvalid_q && m_w_s2m.wready;
   assign ar_hs   = arvalid_q && m_r_s2m.arready;
   assign r_beat  = rready_q && m_r_s2m.rvalid;
   assign b_beat  = bready_q && m_w_s2m.bvalid;
   assign wd_fire = (TIMEOUT != 0) && (wd_q == WD_LIMIT);

   always_comb begin
      state_d   = state_q;
      rsp_d     = rsp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      abort     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_in.addr;
               wdata_d = req_in.wdata;
               wstrb_d = req_in.wstrb;
               if (req_in.we) begin
                  state_d   = WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         RD_ADDR: begin
            if (wd_fire) begin
               abort = 1'b1;
            end else if (ar_hs) begin
               arvalid_d = 1'b0;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            // A beat landing on the watchdog cycle still counts as a good response.
            if (r_beat) begin
               rsp_d   = '{rdata: m_r_s2m.rdata, err: !m_r_s2m.rlast};
               state_d = RESP;
            end else if (wd_fire) begin
               abort = 1'b1;
            end
         end
         WR_REQ: begin
            if (wd_fire) begin
               abort = 1'b1;
            end else begin
               if (aw_hs) begin
                  awvalid_d = 1'b0;
                  aw_done_d = 1'b1;
               end
               if (w_hs) begin
                  wvalid_d = 1'b0;
                  w_done_d = 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  state_d = WR_RESP;
               end
            end
         end
         WR_RESP: begin
            if (b_beat) begin
               rsp_d   = '{rdata: 32'd0, err: 1'b0};
               state_d = RESP;
            end else if (wd_fire) begin
               abort = 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort) begin
         awvalid_d = 1'b0;
         wvalid_d  = 1'b0;
         arvalid_d = 1'b0;
         rsp_d     = '{rdata: 32'd0, err: 1'b1};
         state_d   = RESP;
      end
   end

   // Outputs are registered off the next state so each one lines up with the state it belongs to.
   always_comb begin
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      rready_d    = (state_d != RESP);
      bready_d    = (state_d != RESP);
      wd_d        = in_wait(state_d) ? wd_q + WD_W'(1) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         bready_q    <= 1'b1;
         rready_q    <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         bready_q    <= bready_d;
         rready_q    <= rready_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         wd_q        <= wd_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_q.rdata;
   assign rsp_err   = rsp_q.err;

   assign m_w_m2s = '{awvalid: awvalid_q, awaddr: addr_q, wvalid: wvalid_q,
                      wdata: wdata_q, wstrb: wstrb_q, bready: bready_q};
   assign m_r_m2s = '{arvalid: arvalid_q, araddr: addr_q, rready: rready_q};

endmodule

// File: doc/mem_axi_master.md
Name: mem_axi_master

Overview:
AXI initiator that converts a single simple memory request (load or store) into AXI read or write channel traffic, and returns one response. It is the master end of the OoO_pkg AXI read/write channel structs. It sits between the LSU/IFU request port and the memory-side responder: the simulation SRAM model or a later crossbar. One transaction is outstanding at a time, and a watchdog flags hung responders.

Parameters:
TIMEOUT, 1023, wait-state cycle limit before an error response is forced; 0 disables the watchdog.

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when both valid and ready are high
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address, passed through unchanged
req_wdata  in  32  store data
req_wstrb  in  4  store byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  timeout, or read beat without rlast
m_w_m2s  out  axi_w_m2s_t  awvalid/awaddr/wvalid/wdata/wstrb/bready
m_w_s2m  in  axi_w_s2m_t  awready/wready/bvalid
m_r_m2s  out  axi_r_m2s_t  arvalid/araddr/rready
m_r_s2m  in  axi_r_s2m_t  arready/rvalid/rdata/rlast

Behaviour:
- Reset: state IDLE, and all of the following are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, awvalid, wvalid, arvalid, awaddr, araddr, wdata, wstrb, watchdog count. bready and rready are 1. All outputs are registered.
- Reset mid-transaction: FSM returns to IDLE and drops every valid immediately. The in-flight request is lost with no response.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/wdata/wstrb. Go to WR_REQ if we=1, otherwise RD_ADDR.
  - The cycle after acceptance drives the first valid, so request-to-AXI latency is 1 cycle.
- RD_ADDR:
  - arvalid=1 and araddr=latched addr, both stable until arvalid&&arready.
  - After the handshake, arvalid drops the next cycle and the FSM moves to RD_DATA.
- RD_DATA:
  - rready=1. On rvalid, capture rdata into rsp_rdata.
  - rsp_err = !rlast.
  - Go to RESP.
- WR_REQ:
  - awvalid and wvalid are asserted together in the same cycle.
  - Each drops independently after its own handshake (aw_done/w_done flags), covering the case where awready and wready arrive on different cycles.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, set rsp_rdata=0 and rsp_err=0, then go to RESP.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. This costs one bubble cycle: back-to-back requests are accepted no faster than every transaction + 2 cycles.
- Minimum load round trip against a 1-cycle responder: accept at T0, arvalid at T1, rvalid at T2, rsp_valid at T3.
- Watchdog:
  - Counts cycles spent in RD_ADDR, RD_DATA, WR_REQ and WR_RESP. Clears on entering IDLE.
  - If TIMEOUT != 0 and count == TIMEOUT: drop awvalid/wvalid/arvalid, set rsp_err=1 and rsp_rdata=0, go to RESP.
- Stale beats: in IDLE, bready=rready=1 to drain any rvalid/bvalid that arrives late after a timeout. Drained beats are discarded and never reported.
- Simultaneous events:
  - rvalid arriving in the same cycle the watchdog fires: the data beat wins and no error is raised.
  - bvalid in that same situation behaves the same way: the beat wins.

Decomposition:
- OoO_pkg: reuses the existing axi_w_m2s_t/axi_w_s2m_t/axi_r_m2s_t/axi_r_s2m_t.
- OoO_pkg additions:
  - mem_req_t: we, addr, wdata, wstrb.
  - mem_rsp_t: rdata, err.
  - Constant MEM_TIMEOUT_DEFAULT = 1023.
- The FSM state enum stays local to the module.
- No sub-module. The watchdog is a local counter and is too small to justify splitting out.

Test Plan:
- Load 0x8000_0000 against a responder returning 0xDEAD_BEEF with rlast=1 -> arvalid at T1 with araddr 0x8000_0000; rsp_valid at T3 with rdata 0xDEAD_BEEF and err=0.
- Store addr 0x8000_0010, data 0x1234_5678, wstrb 4'b0011 -> awvalid and wvalid both high at T1 with matching fields; bready high; rsp_valid one cycle after bvalid with rdata=0 and err=0.
- Responder raises awready 3 cycles before wready -> awvalid drops after its handshake; wvalid is held until its own; exactly one bvalid is consumed; exactly one response is produced.
- TIMEOUT=8 and the responder never asserts arready -> after 8 wait cycles arvalid drops and the response has err=1, rdata=0; a late rvalid is drained in IDLE with no second response.
- rsp_ready held low for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable; req_ready stays 0; IDLE is re-entered the cycle after rsp_ready rises.
- Reset asserted in WR_RESP, and separately a read beat with rlast=0 -> after reset all valids are 0 and req_ready=1 the next cycle; the rlast=0 read returns err=1 with the captured rdata.
